trig_tick_gen: RTL and testbench
================================

Name: trig_tick_gen

Overview:
Multi-channel programmable trigger/tick generator for the wb_trigger path. It divides the 100 MHz system clock into selectable trigger periods. Each channel independently produces a square wave, a periodic single-cycle strobe, or a one-shot delay. Period changes are glitch-free: a new selection takes effect only at the channel's terminal count.

Parameters:
NUM_CH, 2, number of independent trigger channels
CNT_W, 26, counter width; must hold the largest table entry
SEL_W, 4, period-select width per channel (table depth 2**SEL_W)
FAST_SIM, 0, 1 = use short simulation period table (P = 4*sel+3)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-low reset
en  in  NUM_CH  per-channel enable, level
sel  in  NUM_CH*SEL_W  per-channel period select; channel i uses bits [i*SEL_W +: SEL_W]
mode  in  NUM_CH*2  per-channel mode: 00 square, 01 strobe, 10 one-shot, 11 reserved (treated as 00)
start  in  NUM_CH  one-shot launch, single-cycle pulse
wave  out  NUM_CH  square output (mode 00), or copy of tick (modes 01/10)
tick  out  NUM_CH  one-cycle strobe at each terminal count
busy  out  NUM_CH  1 while the channel is counting

Behaviour:
- Reset (rst=0, async): counter=0, wave=0, tick=0, busy=0, shadow P=table[0], shadow mode=00.
- Per-channel terminal value P = table(sel); counter counts 0..P, giving P+1 cycles per segment.
- Production table (100 MHz, FAST_SIM=0): 499, 999, 2499999, 3749999, 4999999, 6249999, 7499999, 8749999, 9999999, 11249999, 12499999, 13749999, 14999999, 16249999, 17499999, 34999999.
- Shadow registers (P, mode):
  - Loaded on the en 0->1 transition, on an accepted start, and at every terminal count.
  - sel/mode changes mid-segment never shorten or extend the current segment.
  - No "counter > P" recovery path is needed.
- en=0: counter=0, tick=0, busy=0, wave=0 on the next edge. An in-flight one-shot is aborted.
- Mode 00 (square), while en=1:
  - busy=1.
  - At counter==P: counter<=0, wave toggles, tick=1 for one cycle.
  - Output period = 2*(P+1) cycles.
  - First toggle occurs P+1 cycles after the edge that samples en=1.
- Mode 01 (strobe): same counting as mode 00; wave=tick, giving one pulse every P+1 cycles.
- Mode 10 (one-shot):
  - Idle: busy=0, counter=0.
  - start=1 with en=1: busy<=1, counter<=0.
  - At counter==P: tick=1 (wave=1) for one cycle, busy<=0, counter held at 0.
  - start while busy: ignored.
  - start with en=0: ignored.
  - start in the same cycle as the terminal count: ignored; must be re-issued.
- Switching into or out of mode 10 takes effect at the next shadow load. After entering one-shot, the channel idles until start.
- wave/tick are registered outputs, driven directly from flops.
- Channels are fully independent and share no counters.
- Async reset mid-count: all channels immediately return to reset values.

Decomposition:
- Package trig_pkg:
  - SEL_W and mode encodings (MODE_SQUARE=2'b00, MODE_STROBE=2'b01, MODE_ONESHOT=2'b10).
  - Function period_lut(sel, fast_sim) returning the CNT_W-bit P value for both tables.
- Sub-module trig_tick_ch: one channel holding its counter, shadow registers and mode FSM (IDLE, RUN). The top instantiates NUM_CH copies via generate and slices the sel/mode/start buses.

Test Plan:
- FAST_SIM=1, ch0 mode 00, sel=0 (P=3), en 0->1 -> wave toggles every 4 cycles (period 8); tick high 1 cycle at each toggle; first toggle 4 cycles after en is sampled.
- ch0 square at sel=2 (P=11); change sel to 0 at counter=5 -> current segment still lasts 12 cycles, then segments of 4 cycles.
- ch1 mode 10, sel=1 (P=7), start pulse -> busy=1 for 8 cycles, tick=wave=1 on the 8th; second start during busy ignored; start after busy=0 re-launches.
- ch0 mode 01 sel=3 (P=15) while ch1 mode 00 sel=0 -> ch0 strobe every 16 cycles, ch1 square period 8; no cross-interaction.
- Drop en mid-segment, and separately assert rst low mid-count -> wave=tick=busy=0 (next edge for en, immediately for rst); re-enable restarts the full P+1 count.
- FAST_SIM=0, sel=0 -> tick every 500 cycles (5 us); check sel=15 shadow value is 34999999 and fits CNT_W.

Source files
------------

// File: rtl/trig_pkg.sv
// Shared mode/state encodings and the trigger period lookup (production and short sim tables).
// Pure combinational helpers, no latency; nothing here holds state or applies backpressure.
package trig_pkg;

  localparam int SEL_W = 4;
  localparam int PER_W = 26;

  typedef enum logic [1:0] {
    MODE_SQUARE  = 2'b00,
    MODE_STROBE  = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Terminal count P for a select; a segment lasts P+1 clocks at 100 MHz.
  function automatic logic [PER_W-1:0] period_lut(input logic [SEL_W-1:0] sel, input logic fast_sim);
    logic [PER_W-1:0] p;
    if (fast_sim) begin
      p = PER_W'({sel, 2'b11});
    end else begin
      case (sel)
        4'd0:    p = 26'd499;
        4'd1:    p = 26'd999;
        4'd2:    p = 26'd2499999;
        4'd3:    p = 26'd3749999;
        4'd4:    p = 26'd4999999;
        4'd5:    p = 26'd6249999;
        4'd6:    p = 26'd7499999;
        4'd7:    p = 26'd8749999;
        4'd8:    p = 26'd9999999;
        4'd9:    p = 26'd11249999;
        4'd10:   p = 26'd12499999;
        4'd11:   p = 26'd13749999;
        4'd12:   p = 26'd14999999;
        4'd13:   p = 26'd16249999;
        4'd14:   p = 26'd17499999;
        default: p = 26'd34999999;
      endcase
    end
    return p;
  endfunction

  // The reserved encoding behaves exactly like square.
  function automatic mode_e norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_SQUARE : mode_e'(m);
  endfunction

endpackage

// File: rtl/trig_tick_ch.sv
// One trigger channel: counter, shadowed period/mode and IDLE/RUN FSM; outputs registered one edge after terminal count.
// No backpressure: inputs sampled every clock, a start arriving while busy or at terminal count is dropped.
module trig_tick_ch #(
  parameter int CNT_W    = 26,
  parameter int SEL_W    = 4,
  parameter int FAST_SIM = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEL_W-1:0] sel,
  input  logic [1:0]       mode,
  input  logic             start,
  output logic             wave,
  output logic             tick,
  output logic             busy
);
  import trig_pkg::*;

  localparam int LUT_SEL_W = trig_pkg::SEL_W;
  localparam logic [CNT_W-1:0] P_RST = CNT_W'(period_lut('0, FAST_SIM != 0));

  state_e           state_q, state_d;
  mode_e            sh_mode_q, sh_mode_d, in_mode;
  logic [CNT_W-1:0] cnt_q, cnt_d, sh_p_q, sh_p_d, in_p;
  logic             en_q, wave_q, wave_d, tick_q, tick_d;
  logic             rise, term, accept, load;

  assign in_p    = CNT_W'(period_lut(LUT_SEL_W'(sel), FAST_SIM != 0));
  assign in_mode = norm_mode(mode);

  assign rise   = en & ~en_q;
  assign term   = en & (state_q == ST_RUN) & (cnt_q == sh_p_q);
  // On the enabling edge the freshly selected mode decides whether start is meaningful.
  assign accept = en & start & (state_q == ST_IDLE) &
                  (rise ? (in_mode == MODE_ONESHOT) : (sh_mode_q == MODE_ONESHOT));
  assign load   = rise | accept | term;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = ST_IDLE;
    end else if (load) begin
      if (in_mode != MODE_ONESHOT) begin
        state_d = ST_RUN;
      end else begin
        state_d = accept ? ST_RUN : ST_IDLE;
      end
    end
  end

  always_comb begin
    cnt_d     = '0;
    tick_d    = 1'b0;
    wave_d    = 1'b0;
    sh_p_d    = sh_p_q;
    sh_mode_d = sh_mode_q;
    if (en) begin
      if (load) begin
        sh_p_d    = in_p;
        sh_mode_d = in_mode;
      end else if (state_q == ST_RUN) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      tick_d = term;
      // The segment that just ended is rendered in the mode it was started with.
      if (term) begin
        wave_d = (sh_mode_q == MODE_SQUARE) ? ~wave_q : 1'b1;
      end else begin
        wave_d = (sh_mode_q == MODE_SQUARE) ? wave_q : 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      sh_p_q    <= P_RST;
      sh_mode_q <= MODE_SQUARE;
      en_q      <= 1'b0;
      wave_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sh_p_q    <= sh_p_d;
      sh_mode_q <= sh_mode_d;
      en_q      <= en;
      wave_q    <= wave_d;
      tick_q    <= tick_d;
    end
  end

  assign wave = wave_q;
  assign tick = tick_q;
  assign busy = (state_q == ST_RUN);

  a_cnt_in_range: assert property (@(posedge clk) disable iff (!rst) cnt_q <= sh_p_q);
  a_idle_cnt_zero: assert property (@(posedge clk) disable iff (!rst) (state_q == ST_IDLE) |-> (cnt_q == '0));

endmodule

// File: rtl/trig_tick_gen.sv
// Multi-channel trigger/tick generator: NUM_CH independent channels slicing the shared sel/mode/start buses.
// Outputs registered one edge after each channel's terminal count; no backpressure.
module trig_tick_gen #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 26,
  parameter int SEL_W    = 4,
  parameter int FAST_SIM = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*SEL_W-1:0] sel,
  input  logic [NUM_CH*2-1:0]     mode,
  input  logic [NUM_CH-1:0]       start,
  output logic [NUM_CH-1:0]       wave,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    trig_tick_ch #(
      .CNT_W   (CNT_W),
      .SEL_W   (SEL_W),
      .FAST_SIM(FAST_SIM)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .en   (en[i]),
      .sel  (sel[i*SEL_W +: SEL_W]),
      .mode (mode[i*2 +: 2]),
      .start(start[i]),
      .wave (wave[i]),
      .tick (tick[i]),
      .busy (busy[i])
    );
  end

endmodule

// File: tb/tb_trig_tick_gen.sv
// Bench for trig_tick_gen: short-table instance for timing behaviour, production-table instance for real periods.
`timescale 1ns/1ps
module tb_trig_tick_gen;
  localparam int NUM_CH = 2;
  localparam int SEL_W  = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NUM_CH-1:0]       en, start, wave, tick, busy;
  logic [NUM_CH*SEL_W-1:0] sel;
  logic [NUM_CH*2-1:0]     mode;
  logic                    p_en, p_start, p_wave, p_tick, p_busy;
  logic [SEL_W-1:0]        p_sel;
  logic [1:0]              p_mode;

  always #5 clk = ~clk;

  trig_tick_gen #(.NUM_CH(NUM_CH), .CNT_W(26), .SEL_W(SEL_W), .FAST_SIM(1)) dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .mode(mode), .start(start),
    .wave(wave), .tick(tick), .busy(busy));

  trig_tick_gen #(.NUM_CH(1), .CNT_W(26), .SEL_W(SEL_W), .FAST_SIM(0)) dut_prod (
    .clk(clk), .rst(rst), .en(p_en), .sel(p_sel), .mode(p_mode), .start(p_start),
    .wave(p_wave), .tick(p_tick), .busy(p_busy));

  typedef struct {
    string      name;
    int         ch;
    logic [2:0] wtb;
  } exp_t;

  typedef struct {
    int         ch;
    logic       en;
    logic [3:0] sel;
    logic [1:0] mode;
    logic       start;
    logic [2:0] wtb;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void expect_ch(string nm, int ch, logic w, logic t, logic b);
    exp_t e;
    e.name = nm;
    e.ch   = ch;
    e.wtb  = {w, t, b};
    sb.push_back(e);
  endfunction

  function automatic void add(int ch, logic e, int s, int m, logic st, logic w, logic t, logic b);
    vec_t v;
    v.ch = ch; v.en = e; v.sel = 4'(s); v.mode = 2'(m); v.start = st; v.wtb = {w, t, b};
    tbl.push_back(v);
  endfunction

  // Advance one rising edge, then compare everything queued against the outputs it produced.
  task automatic step();
    exp_t       e;
    logic [2:0] act;
    @(negedge clk);
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {wave[e.ch], tick[e.ch], busy[e.ch]};
      n_cmp++;
      if (act !== e.wtb) begin
        n_bad++;
        $display("FAIL %s ch%0d @%0t: wave/tick/busy=%b expected %b", e.name, e.ch, $time, act, e.wtb);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic w0, w1, t0, t1;
    int   c;

    rst = 1'b0; en = '0; sel = '0; mode = '0; start = '0;
    p_en = 1'b0; p_sel = '0; p_mode = '0; p_start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({wave, tick, busy}), 0);
    check("reset_prod_outputs", int'({p_wave, p_tick, p_busy}), 0);
    rst = 1'b1;
    expect_ch("idle_after_reset", 0, 0, 0, 0);
    expect_ch("idle_after_reset", 1, 0, 0, 0);
    step();

    // ch0 square P=3, en drop mid-segment, re-enable; then ch1 one-shot P=7.
    for (int k = 0; k < 14; k++) add(0, 1, 0, 0, 0, logic'((k / 4) % 2), logic'(k > 0 && k % 4 == 0), 1);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 2, 0, 0, 0, 0);
    add(1, 1, 1, 2, 1, 0, 0, 1);
    add(1, 1, 1, 2, 0, 0, 0, 1);
    add(1, 1, 1, 2, 0, 0, 0, 1);
    add(1, 1, 1, 2, 1, 0, 0, 1);
    for (int k = 5; k <= 8; k++) add(1, 1, 1, 2, 0, 0, 0, 1);
    add(1, 1, 1, 2, 1, 1, 1, 0);
    add(1, 1, 1, 2, 0, 0, 0, 0);
    add(1, 1, 1, 2, 1, 0, 0, 1);
    for (int k = 12; k <= 18; k++) add(1, 1, 1, 2, 0, 0, 0, 1);
    add(1, 1, 1, 2, 0, 1, 1, 0);
    add(1, 1, 1, 2, 0, 0, 0, 0);
    add(1, 0, 1, 2, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      en[tbl[i].ch]                     = tbl[i].en;
      sel[tbl[i].ch*SEL_W +: SEL_W]     = tbl[i].sel;
      mode[tbl[i].ch*2 +: 2]            = tbl[i].mode;
      start[tbl[i].ch]                  = tbl[i].start;
      expect_ch($sformatf("tbl[%0d]", i), tbl[i].ch, tbl[i].wtb[2], tbl[i].wtb[1], tbl[i].wtb[0]);
      step();
    end

    // ch0 square (reserved encoding) P=11, sel drops to P=3 while counter=5.
    mode[1:0] = 2'b11; sel[3:0] = 4'd2; en[0] = 1'b1; w0 = 1'b0;
    for (int k = 0; k <= 24; k++) begin
      if (k == 6) sel[3:0] = 4'd0;
      t0 = (k == 12 || k == 16 || k == 20 || k == 24);
      if (t0) w0 = ~w0;
      expect_ch($sformatf("sel_change k=%0d", k), 0, w0, t0, 1);
      step();
    end
    en[0] = 1'b0;
    expect_ch("sel_change_off", 0, 0, 0, 0);
    step();

    // ch0 strobe P=15 alongside ch1 square P=3.
    mode = {2'b00, 2'b01}; sel = {4'd0, 4'd3}; en = 2'b11; w1 = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      t0 = (k == 16 || k == 32);
      t1 = (k > 0 && k % 4 == 0);
      if (t1) w1 = ~w1;
      expect_ch($sformatf("dual k=%0d", k), 0, t0, t0, 1);
      expect_ch($sformatf("dual k=%0d", k), 1, w1, t1, 1);
      step();
    end
    step();
    check("busy_before_rst", int'(busy), 3);

    // Asynchronous reset between edges clears outputs without a clock.
    #2 rst = 1'b0;
    #1 check("async_rst_clear", int'({wave, tick, busy}), 0);
    @(negedge clk);
    check("rst_held_clear", int'({wave, tick, busy}), 0);
    rst = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      expect_ch($sformatf("post_rst k=%0d", k), 1, logic'(k == 4), logic'(k == 4), 1);
      expect_ch($sformatf("post_rst k=%0d", k), 0, 0, 0, 1);
      step();
    end
    en = '0;
    expect_ch("all_off", 0, 0, 0, 0);
    expect_ch("all_off", 1, 0, 0, 0);
    step();

    // Production table: 500-cycle period, then sel=15 shadow load at the next terminal count.
    p_en = 1'b1; p_sel = 4'd0; p_mode = 2'b00;
    c = 0;
    do begin @(negedge clk); c++; end while (!p_tick && c < 2000);
    check("prod_first_tick_latency", c - 1, 500);
    check("prod_busy", int'(p_busy), 1);
    p_sel = 4'd15;
    c = 0;
    do begin @(negedge clk); c++; end while (!p_tick && c < 2000);
    check("prod_tick_period", c, 500);
    check("prod_sel15_shadow", int'(dut_prod.g_ch[0].u_ch.sh_p_q), 34999999);
    p_en = 1'b0;
    @(negedge clk);
    check("prod_off", int'({p_wave, p_tick, p_busy}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
